// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param: parametrised UART transmitter with a ready/valid input FIFO.
// Frames are 1 start bit, DATA_WIDTH data bits sent LSB first, an optional parity
// bit and 1 or 2 stop bits. Every bit lasts CLKS_PER_BIT clocks. Queued words go
// out back-to-back, with no idle clock between frames.
//
// Ports:
//   clk         clock; all state updates happen on posedge
//   reset       asynchronous, active-high reset
//   P_DATA      payload word to queue
//   DATA_VALID  source offers P_DATA this cycle
//   READY       FIFO can accept a word (equals !full)
//   PAR_EN      1 = insert a parity bit (latched per frame)
//   PAR_TYP     0 = even parity, 1 = odd parity (latched per frame)
//   STOP2       1 = two stop bits (latched per frame)
//   TX_OUT      serial line, idles high (registered)
//   Busy        a frame is in progress on TX_OUT (registered)
//   FIFO_COUNT  number of entries currently queued
module uart_tx_fifo_param #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_WIDTH-1:0]           P_DATA,
  input  logic                            DATA_VALID,
  output logic                            READY,
  input  logic                            PAR_EN,
  input  logic                            PAR_TYP,
  input  logic                            STOP2,
  output logic                            TX_OUT,
  output logic                            Busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] FIFO_COUNT
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // ---------------- input FIFO ----------------
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  full, empty, push, pop;
  logic [DATA_WIDTH-1:0] head;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  // READY comes only from the registered count, so it stays low while full
  // even on an edge where a pop also happens.
  assign push  = DATA_VALID && !full;
  assign head  = mem[rd_ptr];

  assign READY      = !full;
  assign FIFO_COUNT = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= P_DATA;
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- transmit FSM ----------------
  state_t                state, state_n;
  logic [BW-1:0]         baud, baud_n;
  logic [IW-1:0]         idx, idx_n;
  logic                  stop_cnt, stop_cnt_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic                  par_en_q, par_en_n;
  logic                  stop2_q, stop2_n;
  logic                  parity_q, parity_n;
  logic                  tx, tx_n;
  logic                  busy, busy_n;
  logic                  bit_done, load;

  assign bit_done = (baud == BW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud     <= '0;
      idx      <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      parity_q <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      baud     <= baud_n;
      idx      <= idx_n;
      stop_cnt <= stop_cnt_n;
      shreg    <= shreg_n;
      par_en_q <= par_en_n;
      stop2_q  <= stop2_n;
      parity_q <= parity_n;
      tx       <= tx_n;
      busy     <= busy_n;
    end
  end

  // TX_OUT/Busy are computed one state ahead and registered, so the value
  // for a bit is loaded on the same edge the state enters that bit.
  always_comb begin
    state_n    = state;
    baud_n     = (state == IDLE || bit_done) ? '0 : baud + BW'(1);
    idx_n      = idx;
    stop_cnt_n = stop_cnt;
    shreg_n    = shreg;
    par_en_n   = par_en_q;
    stop2_n    = stop2_q;
    parity_n   = parity_q;
    tx_n       = tx;
    busy_n     = busy;
    load       = 1'b0;
    pop        = 1'b0;

    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (!empty) load = 1'b1;
      end
      START: begin
        if (bit_done) begin
          state_n = DATA;
          idx_n   = '0;
          tx_n    = shreg[0];
          shreg_n = shreg >> 1;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx == IW'(DATA_WIDTH - 1)) begin
            stop_cnt_n = 1'b0;
            if (par_en_q) begin
              state_n = PARITY;
              tx_n    = parity_q;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            idx_n   = idx + IW'(1);
            tx_n    = shreg[0];
            shreg_n = shreg >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_n    = STOP;
          stop_cnt_n = 1'b0;
          tx_n       = 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (stop2_q && !stop_cnt) begin
            stop_cnt_n = 1'b1;
          end else if (!empty) begin
            load = 1'b1;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
            busy_n  = 1'b0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase

    // Shared frame start from IDLE or straight out of STOP: pop the head and
    // freeze the frame configuration, including its parity bit.
    if (load) begin
      pop      = 1'b1;
      state_n  = START;
      baud_n   = '0;
      shreg_n  = head;
      par_en_n = PAR_EN;
      stop2_n  = STOP2;
      parity_n = PAR_TYP ? ~^head : ^head;
      tx_n     = 1'b0;
      busy_n   = 1'b1;
    end
  end

  assign TX_OUT = tx;
  assign Busy   = busy;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// tb_uart_tx_fifo_param: directed bench for uart_tx_fifo_param.
// dut0: DATA_WIDTH=8, CLKS_PER_BIT=4, FIFO_DEPTH=4.
// dut1: DATA_WIDTH=5, CLKS_PER_BIT=1, FIFO_DEPTH=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_tx_fifo_param;

  logic       clk;
  logic       rst0, valid0, ready0, par_en0, par_typ0, stop20, tx0, busy0;
  logic [7:0] data0;
  logic [2:0] count0;
  logic       rst1, valid1, ready1, par_en1, par_typ1, stop21, tx1, busy1;
  logic [4:0] data1;
  logic [2:0] count1;

  int n_asserts = 0;
  int n_fail    = 0;

  uart_tx_fifo_param #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .reset(rst0), .P_DATA(data0), .DATA_VALID(valid0), .READY(ready0),
    .PAR_EN(par_en0), .PAR_TYP(par_typ0), .STOP2(stop20), .TX_OUT(tx0),
    .Busy(busy0), .FIFO_COUNT(count0)
  );

  uart_tx_fifo_param #(.DATA_WIDTH(5), .CLKS_PER_BIT(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .reset(rst1), .P_DATA(data1), .DATA_VALID(valid1), .READY(ready1),
    .PAR_EN(par_en1), .PAR_TYP(par_typ1), .STOP2(stop21), .TX_OUT(tx1),
    .Busy(busy1), .FIFO_COUNT(count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One word into an idle DUT; TX_OUT must still be high right after the push edge.
  task automatic push(input int sel, input logic [7:0] d);
    @(negedge clk);
    if (sel == 0) begin data0 = d; valid0 = 1'b1; end
    else          begin data1 = d[4:0]; valid1 = 1'b1; end
    @(negedge clk);
    valid0 = 1'b0;
    valid1 = 1'b0;
    chk("latency_idle", (sel == 0) ? tx0 : tx1, 1'b1);
  endtask

  // bits holds the frame in transmission order, first bit in the MSB of n bits.
  task automatic check_frame(input int sel, input string tag, input logic [15:0] bits,
                             input int n, input int cpb, input int flip_at);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        chk({tag, "_tx"},   (sel == 0) ? tx0 : tx1, bits[n-1-i]);
        chk({tag, "_busy"}, (sel == 0) ? busy0 : busy1, 1'b1);
        if (i * cpb + c == flip_at) par_typ0 = ~par_typ0;
      end
    end
    @(negedge clk);
    chk({tag, "_end_tx"},   (sel == 0) ? tx0 : tx1, 1'b1);
    chk({tag, "_end_busy"}, (sel == 0) ? busy0 : busy1, 1'b0);
  endtask

  // Start bit, 8 data bits LSB first, one stop bit.
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return d[k-1];
  endfunction

  initial begin
    logic pend;
    int   idx;

    rst0 = 1'b1; valid0 = 1'b0; data0 = '0; par_en0 = 1'b0; par_typ0 = 1'b0; stop20 = 1'b0;
    rst1 = 1'b1; valid1 = 1'b0; data1 = '0; par_en1 = 1'b0; par_typ1 = 1'b0; stop21 = 1'b0;
    #12;
    chk("rst_tx",    tx0, 1'b1);
    chk("rst_busy",  busy0, 1'b0);
    chk("rst_ready", ready0, 1'b1);
    chk("rst_count", count0, 3'd0);
    chk("rst1_tx",   tx1, 1'b1);
    @(negedge clk);
    rst0 = 1'b0;
    rst1 = 1'b0;
    repeat (2) @(negedge clk);

    // 0xA5, no parity, one stop bit
    push(0, 8'hA5);
    check_frame(0, "a5", 16'b0101001011, 10, 4, -1);

    // 0x03 even parity -> parity 0
    par_en0 = 1'b1; par_typ0 = 1'b0;
    push(0, 8'h03);
    check_frame(0, "par_even", 16'b01100000001, 11, 4, -1);

    // 0x03 odd parity -> parity 1, PAR_TYP flipped mid-frame has no effect
    par_typ0 = 1'b1;
    push(0, 8'h03);
    check_frame(0, "par_odd", 16'b01100000011, 11, 4, 10);
    par_en0 = 1'b0; par_typ0 = 1'b0;

    // 0xFF with two stop bits
    stop20 = 1'b1;
    push(0, 8'hFF);
    check_frame(0, "stop2", 16'b01111111111, 11, 4, -1);
    stop20 = 1'b0;

    // Back-to-back stream 0x10..0x15 with DATA_VALID held high until accepted.
    idx = 0;
    @(negedge clk);
    data0 = 8'h10; valid0 = 1'b1; pend = ready0;
    for (int t = 0; t <= 241; t++) begin
      @(negedge clk);
      if (pend) idx++;
      if (t == 0) chk("s_latency", tx0, 1'b1);
      if (t >= 1 && t <= 240) begin
        chk("s_tx", tx0, frame_bit(8'h10 + 8'((t - 1) / 40), ((t - 1) % 40) / 4));
        chk("s_busy", busy0, 1'b1);
      end
      if (t == 4)   begin chk("s_full_ready", ready0, 1'b0); chk("s_full_count", count0, 3'd4); end
      if (t == 40)  begin chk("s_hold_ready", ready0, 1'b0); chk("s_hold_count", count0, 3'd4); end
      if (t == 41)  begin chk("s_pop_ready", ready0, 1'b1); chk("s_pop_count", count0, 3'd3); end
      if (t == 42)  begin chk("s_last_count", count0, 3'd4); chk("s_accepted", idx, 6); end
      if (t == 241) begin
        chk("s_end_tx", tx0, 1'b1);
        chk("s_end_busy", busy0, 1'b0);
        chk("s_end_count", count0, 3'd0);
      end
      if (idx < 6) begin data0 = 8'h10 + 8'(idx); valid0 = 1'b1; pend = ready0; end
      else         begin valid0 = 1'b0; pend = 1'b0; end
    end

    // Asynchronous reset during data bit 3 with two words queued.
    @(negedge clk);
    data0 = 8'hA5; valid0 = 1'b1;
    @(negedge clk);
    data0 = 8'h3C;
    @(negedge clk);
    data0 = 8'h5A;
    @(negedge clk);
    valid0 = 1'b0;
    repeat (16) @(negedge clk);
    chk("r_pre_tx", tx0, 1'b0);
    chk("r_pre_count", count0, 3'd2);
    #1 rst0 = 1'b1;
    #1;
    chk("r_tx", tx0, 1'b1);
    chk("r_busy", busy0, 1'b0);
    chk("r_count", count0, 3'd0);
    chk("r_ready", ready0, 1'b1);
    @(negedge clk);
    rst0 = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk("r_idle_tx", tx0, 1'b1);
      chk("r_idle_busy", busy0, 1'b0);
    end
    chk("r_idle_count", count0, 3'd0);
    push(0, 8'hA5);
    check_frame(0, "r_new", 16'b0101001011, 10, 4, -1);

    // 5-bit word, one clock per bit, odd parity
    par_en1 = 1'b1; par_typ1 = 1'b1;
    push(1, 8'h16);
    check_frame(1, "w5", 16'b00110101, 8, 1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
